// File: rtl/kbd_bus_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : kbd_bus_ctrl_pkg
// Description : Shared definitions for the BK-0010 keyboard bus controller:
//               register offsets, default interrupt vectors, FIFO entry
//               layout, status bit positions and FSM state encodings.
// Revision    : 1.0  initial release
// ============================================================================
package kbd_bus_ctrl_pkg;

    // Register window offsets selected by bus_a1
    localparam logic c_reg_status = 1'b0;   // 177660
    localparam logic c_reg_data   = 1'b1;   // 177662

    // Default interrupt vectors
    localparam logic [7:0] c_vec_kbd_def = 8'o060;
    localparam logic [7:0] c_vec_ar2_def = 8'o274;

    // FIFO entry layout: {ar2, code[6:0]}
    localparam int c_ent_w    = 8;
    localparam int c_ent_ar2  = 7;
    localparam int c_code_w   = 7;

    // Status register bit positions
    localparam int c_sts_ready   = 7;
    localparam int c_sts_int_dis = 6;

    // Drain FSM: one idle state, one recovery cycle after each acknowledge
    typedef enum logic [0:0] {
        D_IDLE = 1'b0,
        D_CLR  = 1'b1
    } drain_state_t;

    // Interrupt FSM
    typedef enum logic [0:0] {
        I_IDLE = 1'b0,
        I_PEND = 1'b1
    } irq_state_t;

    // Vector chosen by the AR2 qualifier of a FIFO entry
    function automatic logic [7:0] sel_vector(
        input logic [c_ent_w-1:0] ent,
        input logic [7:0]         vec_kbd,
        input logic [7:0]         vec_ar2
    );
        return ent[c_ent_ar2] ? vec_ar2 : vec_kbd;
    endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_bus_ctrl_fifo.sv
`default_nettype none
// ============================================================================
// Module      : kbd_bus_ctrl_fifo
// Description : Small synchronous type-ahead FIFO. Head is presented
//               combinationally (first-word fall-through). Push while full
//               and pop while empty are ignored.
// Ports       : mclk     in   clock
//               reset_n  in   asynchronous active-low reset
//               push     in   write din at the tail
//               pop      in   discard the head entry
//               din      in   WIDTH-bit entry
//               head     out  current head entry (valid when !empty)
//               full     out  count == DEPTH
//               empty    out  count == 0
// Revision    : 1.0  initial release
// ============================================================================
module kbd_bus_ctrl_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             mclk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_wr_en;
    logic w_rd_en;

    // A single-entry FIFO keeps both pointers parked at slot 0; otherwise
    // the power-of-two depth makes the natural binary wrap correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (DEPTH == 1) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (r_count == c_depth);
    assign empty   = (r_count == '0);
    assign w_wr_en = push & ~full;
    assign w_rd_en = pop & ~empty;
    assign head    = r_mem[r_rd_ptr];

    // Storage carries no reset: contents are only observed through count
    always_ff @(posedge mclk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_rd_en) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            // Simultaneous push and pop leave the count unchanged
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/kbd_bus_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : kbd_bus_ctrl
// Description : Bus-side PS/2 keyboard controller for the BK-0010. Drains
//               codes from kbd_intf into a type-ahead FIFO, serves the
//               177660 status / 177662 data registers and schedules the
//               keyboard interrupt (VEC_KBD normal, VEC_AR2 for AR2 keys).
// Ports       : mclk, reset_n            clock, async active-low reset
//               bus_sel/a1/rd/wr/din     register window access
//               bus_dout                 registered read data
//               kbd_available/ascii/ar2  code offered by kbd_intf
//               kbd_read                 one-cycle acknowledge to kbd_intf
//               irq, irq_vector, iack    interrupt request/vector/acknowledge
// Revision    : 1.0  initial release
// ============================================================================
module kbd_bus_ctrl
    import kbd_bus_ctrl_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter logic [7:0] VEC_KBD = c_vec_kbd_def,
    parameter logic [7:0] VEC_AR2 = c_vec_ar2_def
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic        bus_sel,
    input  logic        bus_a1,
    input  logic        bus_rd,
    input  logic        bus_wr,
    input  logic [15:0] bus_din,
    output logic [15:0] bus_dout,
    input  logic        kbd_available,
    input  logic [6:0]  kbd_ascii,
    input  logic        kbd_ar2,
    output logic        kbd_read,
    output logic        irq,
    output logic [7:0]  irq_vector,
    input  logic        iack
);

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [c_ent_w-1:0] w_head;

    kbd_bus_ctrl_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_ent_w)
    ) u_fifo (
        .mclk    (mclk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     ({kbd_ar2, kbd_ascii}),
        .head    (w_head),
        .full    (w_full),
        .empty   (w_empty)
    );

    // ------------------------------------------------------------------
    // Register decode
    // ------------------------------------------------------------------
    logic        w_rd_status;
    logic        w_rd_data;
    logic        w_wr_status;
    logic        w_int_dis_nx;
    logic [15:0] w_status_word;
    logic        w_unused_din;

    logic                r_int_dis;
    logic [c_code_w-1:0] r_data_latch;
    logic [15:0]         r_bus_dout;

    assign w_rd_status = bus_sel & bus_rd & (bus_a1 == c_reg_status);
    assign w_rd_data   = bus_sel & bus_rd & (bus_a1 == c_reg_data);
    assign w_wr_status = bus_sel & bus_wr & (bus_a1 == c_reg_status);
    assign w_pop       = w_rd_data & ~w_empty;

    // Value int_dis takes at the next edge; the IRQ FSM looks at this so a
    // status write withdraws or re-raises the request one cycle later.
    assign w_int_dis_nx = w_wr_status ? bus_din[c_sts_int_dis] : r_int_dis;

    assign w_status_word = {8'b0, ~w_empty, r_int_dis, 6'b0};

    // Only bit 6 of a status write is meaningful
    assign w_unused_din = ^{bus_din[15:7], bus_din[5:0]};

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_int_dis    <= 1'b0;
            r_data_latch <= '0;
            r_bus_dout   <= '0;
        end else begin
            if (w_wr_status) begin
                r_int_dis <= bus_din[c_sts_int_dis];
            end
            if (w_rd_status) begin
                r_bus_dout <= w_status_word;
            end else if (w_rd_data) begin
                if (!w_empty) begin
                    r_bus_dout   <= {9'b0, w_head[c_code_w-1:0]};
                    r_data_latch <= w_head[c_code_w-1:0];
                end else begin
                    // Empty read repeats the last code delivered
                    r_bus_dout <= {9'b0, r_data_latch};
                end
            end
        end
    end

    assign bus_dout = r_bus_dout;

    // ------------------------------------------------------------------
    // Drain FSM: acknowledge in the push cycle, then sit out one cycle so
    // kbd_intf has time to drop available before it is looked at again.
    // ------------------------------------------------------------------
    drain_state_t r_dstate;
    drain_state_t w_dstate_nx;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_dstate <= D_IDLE;
        end else begin
            r_dstate <= w_dstate_nx;
        end
    end

    always_comb begin
        w_dstate_nx = r_dstate;
        w_push      = 1'b0;
        case (r_dstate)
            D_IDLE: begin
                // When full the code is simply left waiting in kbd_intf
                if (kbd_available && !w_full) begin
                    w_push      = 1'b1;
                    w_dstate_nx = D_CLR;
                end
            end
            D_CLR: begin
                w_dstate_nx = D_IDLE;
            end
            default: begin
                w_dstate_nx = D_IDLE;
            end
        endcase
    end

    assign kbd_read = w_push;

    // ------------------------------------------------------------------
    // IRQ FSM. r_serviced marks the current head as already acknowledged;
    // any pop moves to a new head and clears it.
    // ------------------------------------------------------------------
    irq_state_t r_istate;
    irq_state_t w_istate_nx;
    logic       r_irq;
    logic       w_irq_nx;
    logic [7:0] r_irq_vector;
    logic [7:0] w_vec_nx;
    logic       r_serviced;
    logic       w_serviced_nx;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_istate     <= I_IDLE;
            r_irq        <= 1'b0;
            r_irq_vector <= '0;
            r_serviced   <= 1'b0;
        end else begin
            r_istate     <= w_istate_nx;
            r_irq        <= w_irq_nx;
            r_irq_vector <= w_vec_nx;
            r_serviced   <= w_serviced_nx;
        end
    end

    always_comb begin
        w_istate_nx   = r_istate;
        w_irq_nx      = r_irq;
        w_vec_nx      = r_irq_vector;
        w_serviced_nx = w_pop ? 1'b0 : r_serviced;
        case (r_istate)
            I_IDLE: begin
                // Hold off while a pop is changing the head this cycle
                if (!w_empty && !w_int_dis_nx && !r_serviced && !w_pop) begin
                    w_istate_nx = I_PEND;
                    w_irq_nx    = 1'b1;
                    w_vec_nx    = sel_vector(w_head, VEC_KBD, VEC_AR2);
                end
            end
            I_PEND: begin
                if (w_pop || w_int_dis_nx) begin
                    // Withdrawn: head went away or interrupts got masked
                    w_istate_nx = I_IDLE;
                    w_irq_nx    = 1'b0;
                end else if (iack) begin
                    w_istate_nx   = I_IDLE;
                    w_irq_nx      = 1'b0;
                    w_serviced_nx = 1'b1;
                end
            end
            default: begin
                w_istate_nx = I_IDLE;
                w_irq_nx    = 1'b0;
            end
        endcase
    end

    assign irq        = r_irq;
    assign irq_vector = r_irq_vector;

endmodule
`default_nettype wire
